// File: rtl/crypto_pkg.sv
// Shared types, constants and LFSR helpers for the message encryptor.
package crypto_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCfg,
        StRun,
        StDone
    } state_t;

    localparam logic [7:0]  SPACE     = 8'h20;
    localparam int unsigned PRE_MIN   = 10;
    localparam int unsigned PRE_MAX   = 26;
    localparam int unsigned PAD_LIMIT = 61;

    function automatic logic [6:0] lfsr_next(input logic [6:0] state, input logic [6:0] taps);
        return {state[5:0], ^(state & taps)};
    endfunction

    function automatic logic [6:0] clamp_pre(input logic [7:0] raw);
        if (raw < 8'(PRE_MIN)) return 7'(PRE_MIN);
        if (raw > 8'(PRE_MAX)) return 7'(PRE_MAX);
        return raw[6:0];
    endfunction

endpackage

// File: rtl/lfsr_encrypt_engine_lfsr7.sv
// 7-bit Fibonacci LFSR register; a zero seed is replaced by 1 so it never locks up.
module lfsr7
    import crypto_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] init,
    input  logic       advance,
    input  logic [6:0] taps,
    output logic [6:0] state
);

    logic [6:0] state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else if (load) begin
            state_q <= (init == 7'd0) ? 7'h01 : init;
        end else if (advance) begin
            state_q <= lfsr_next(state_q, taps);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// Reads config and plaintext from data memory, pads to 64 bytes, XORs with an LFSR
// stream and writes parity-tagged ciphertext back, one byte per cycle.
module lfsr_encrypt_engine
    import crypto_pkg::*;
#(
    parameter int unsigned MSG_LEN  = 64,
    parameter int unsigned OUT_BASE = 64,
    parameter int unsigned CFG_BASE = 61
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic [7:0] RdAddr,
    input  logic [7:0] RdData,
    output logic       WrEn,
    output logic [7:0] WrAddr,
    output logic [7:0] WrData
);

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [6:0] pre_q, pre_d;
    logic [6:0] taps_q, taps_d;
    logic       armed_q, armed_d;
    logic       pad_q, pad_d;

    logic       lfsr_load, lfsr_advance;
    logic [6:0] lfsr_state;
    logic [6:0] rel;
    logic       in_data;
    logic [7:0] plain;
    logic [7:0] cipher_x;

    lfsr7 u_lfsr (
        .clk     (Clk),
        .rst     (Reset),
        .load    (lfsr_load),
        .init    (RdData[6:0]),
        .advance (lfsr_advance),
        .taps    (taps_q),
        .state   (lfsr_state)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pre_q   <= '0;
            taps_q  <= '0;
            armed_q <= 1'b0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            taps_q  <= taps_d;
            armed_q <= armed_d;
            pad_q   <= pad_d;
        end
    end

    // Start high overrides every state; launch needs a high-then-low sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (Start) begin
            state_d = StIdle;
            cnt_d   = '0;
            armed_d = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (armed_q) begin
                        state_d = StCfg;
                        cnt_d   = '0;
                        armed_d = 1'b0;
                    end
                end
                StCfg: begin
                    if (cnt_q == 7'd3) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                StRun: begin
                    if (cnt_q == 7'(MSG_LEN)) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                StDone:  ;
                default: state_d = StIdle;
            endcase
        end
    end

    // In RUN, cycle i issues the read for byte i and writes byte i-1.
    always_comb begin
        rel          = cnt_q - pre_q;
        in_data      = (cnt_q >= pre_q) && (rel < 7'(PAD_LIMIT));
        plain        = pad_q ? SPACE : RdData;
        cipher_x     = plain ^ {1'b0, lfsr_state};
        RdAddr       = '0;
        WrEn         = 1'b0;
        WrAddr       = '0;
        WrData       = '0;
        pre_d        = pre_q;
        taps_d       = taps_q;
        pad_d        = pad_q;
        lfsr_load    = 1'b0;
        lfsr_advance = 1'b0;
        case (state_q)
            StCfg: begin
                if (cnt_q < 7'd3) begin
                    RdAddr = 8'(CFG_BASE) + {1'b0, cnt_q};
                end
                case (cnt_q)
                    7'd1:    pre_d     = clamp_pre(RdData);
                    7'd2:    taps_d    = RdData[6:0];
                    7'd3:    lfsr_load = 1'b1;
                    default: ;
                endcase
            end
            StRun: begin
                if (cnt_q < 7'(MSG_LEN)) begin
                    pad_d = !in_data;
                    if (in_data) begin
                        RdAddr = {1'b0, rel};
                    end
                end
                if (cnt_q != 7'd0) begin
                    WrEn         = 1'b1;
                    WrAddr       = 8'(OUT_BASE) + {1'b0, cnt_q - 7'd1};
                    WrData       = {^cipher_x[6:0], cipher_x[6:0]};
                    lfsr_advance = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign Ack = (state_q == StDone);

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Self-checking bench: behavioural data memory, scoreboard of expected writes,
// table-driven configurations plus abort/reset/random sequences.
module tb_lfsr_encrypt_engine;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic [7:0] RdAddr;
    logic [7:0] RdData;
    logic       WrEn;
    logic [7:0] WrAddr;
    logic [7:0] WrData;
    logic       clr_out;

    always #5 Clk = ~Clk;

    lfsr_encrypt_engine #(
        .MSG_LEN  (64),
        .OUT_BASE (64),
        .CFG_BASE (61)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Ack    (Ack),
        .RdAddr (RdAddr),
        .RdData (RdData),
        .WrEn   (WrEn),
        .WrAddr (WrAddr),
        .WrData (WrData)
    );

    logic [7:0] dm_init [0:255];
    logic [7:0] out_mem [0:63];
    logic [7:0] prev_out [0:63];
    logic [7:0] exp_arr [0:63];

    always @(posedge Clk) begin
        RdData <= dm_init[RdAddr];
        if (clr_out) begin
            for (int a = 0; a < 64; a++) out_mem[a] <= 8'hEE;
        end else if (WrEn === 1'b1 && WrAddr >= 8'd64) begin
            out_mem[WrAddr[5:0]] <= WrData;
        end
    end

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests_run    = 0;
    int  tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin : monitor
        wr_t e;
        if (WrEn === 1'b1) begin
            check("wr_even_parity", 32'(^WrData), 32'd0);
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         WrAddr, WrData);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(WrAddr), 32'(e.addr));
                check("wr_data", 32'(WrData), 32'(e.data));
            end
        end
    end

    task automatic fill_dm(input logic [7:0] pre, input logic [7:0] taps,
                           input logic [7:0] init, input bit rnd);
        for (int a = 0; a < 61; a++) begin
            if (rnd) dm_init[a] = 8'($urandom);
            else     dm_init[a] = (a == 0) ? 8'h41 : 8'h20;
        end
        dm_init[61] = pre;
        dm_init[62] = taps;
        dm_init[63] = init;
    endtask

    // Reference model of the padded message and keystream.
    task automatic push_expected();
        int         pre;
        logic [6:0] l;
        logic [6:0] t;
        logic [7:0] p;
        logic [7:0] x;
        wr_t        w;
        pre = int'(dm_init[61]);
        if (pre < 10) pre = 10;
        if (pre > 26) pre = 26;
        t = dm_init[62][6:0];
        l = dm_init[63][6:0];
        if (l == 7'd0) l = 7'h01;
        exp_q.delete();
        for (int k = 0; k < 64; k++) begin
            if (k < pre || (k - pre) >= 61) p = 8'h20;
            else                            p = dm_init[k - pre];
            x          = p ^ {1'b0, l};
            exp_arr[k] = {^x[6:0], x[6:0]};
            w.addr     = 8'(64 + k);
            w.data     = exp_arr[k];
            exp_q.push_back(w);
            l = {l[5:0], ^(l & t)};
        end
    endtask

    task automatic launch();
        @(negedge Clk);
        Start   = 1'b1;
        clr_out = 1'b1;
        @(negedge Clk);
        Start   = 1'b0;
        clr_out = 1'b0;
    endtask

    task automatic run_full();
        int lat;
        launch();
        @(posedge Clk);
        lat = 0;
        while (lat < 200) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
            if (Ack === 1'b1) break;
        end
        check("ack_latency", 32'(lat), 32'd69);
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge Clk);
        check("done_holds_ack", 32'(Ack), 32'd1);
    endtask

    function automatic int count_out_mismatch();
        int n = 0;
        for (int k = 0; k < 64; k++) if (out_mem[k] !== exp_arr[k]) n++;
        return n;
    endfunction

    typedef struct {
        logic [7:0] pre;
        logic [7:0] taps;
        logic [7:0] init;
        logic [7:0] exp_b0;
        bit         same_prev;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] head_exp [0:5];
    logic [7:0] tap_list [0:8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int found;

        vecs[0] = '{8'd10, 8'h60, 8'h01, 8'h21, 1'b0};
        vecs[1] = '{8'd3,  8'h60, 8'h01, 8'h21, 1'b1};
        vecs[2] = '{8'd10, 8'h60, 8'h00, 8'h21, 1'b1};
        vecs[3] = '{8'd26, 8'h60, 8'h01, 8'h21, 1'b0};
        vecs[4] = '{8'd40, 8'h60, 8'h01, 8'h21, 1'b1};
        vecs[5] = '{8'd17, 8'h48, 8'h7F, 8'h5F, 1'b0};
        head_exp = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h00};
        tap_list = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};

        Reset   = 1'b1;
        Start   = 1'b0;
        clr_out = 1'b0;
        for (int a = 0; a < 256; a++) dm_init[a] = 8'h00;

        #12;
        check("rst_ack",    32'(Ack),    32'd0);
        check("rst_wren",   32'(WrEn),   32'd0);
        check("rst_wraddr", 32'(WrAddr), 32'd0);
        check("rst_wrdata", 32'(WrData), 32'd0);
        check("rst_rdaddr", 32'(RdAddr), 32'd0);

        // Start low after reset: armed is clear, so nothing may launch.
        @(negedge Clk);
        Reset = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge Clk);
            if (RdAddr !== 8'd0) n++;
        end
        check("no_launch_after_reset", 32'(n), 32'd0);
        check("no_launch_ack", 32'(Ack), 32'd0);

        for (int i = 0; i < 6; i++) begin
            fill_dm(vecs[i].pre, vecs[i].taps, vecs[i].init, 1'b0);
            push_expected();
            run_full();
            check("byte0", 32'(out_mem[0]), 32'(vecs[i].exp_b0));
            if (vecs[i].same_prev) begin
                n = 0;
                for (int k = 0; k < 64; k++) if (out_mem[k] !== prev_out[k]) n++;
                check("same_as_prev_cfg", 32'(n), 32'd0);
            end
            if (i == 0) begin
                for (int k = 0; k < 6; k++) check("head_byte", 32'(out_mem[k]), 32'(head_exp[k]));
            end
            for (int k = 0; k < 64; k++) prev_out[k] = out_mem[k];
        end

        // Abort at RUN i=20: the write of addr 83 still lands, nothing after it.
        fill_dm(8'd10, 8'h60, 8'h01, 1'b1);
        push_expected();
        launch();
        @(posedge Clk);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge Clk);
            #1;
            if (WrEn === 1'b1 && WrAddr === 8'd83) begin
                found = 1;
                break;
            end
        end
        check("abort_point_reached", 32'(found), 32'd1);
        Start = 1'b1;
        exp_q.delete();
        repeat (80) @(negedge Clk);
        check("abort_ack_low", 32'(Ack), 32'd0);
        check("abort_last_write", 32'(out_mem[19]), 32'(exp_arr[19]));
        n = 0;
        for (int k = 20; k < 64; k++) if (out_mem[k] !== 8'hEE) n++;
        check("abort_tail_untouched", 32'(n), 32'd0);
        push_expected();
        run_full();
        check("relaunch_full_image", 32'(count_out_mismatch()), 32'd0);

        // Reset mid-CFG with Start held low: must stay idle until Start toggles.
        fill_dm(8'd12, 8'h5C, 8'h33, 1'b1);
        push_expected();
        launch();
        @(posedge Clk);
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        exp_q.delete();
        #2;
        Reset = 1'b0;
        n = 0;
        repeat (100) begin
            @(negedge Clk);
            if (RdAddr !== 8'd0) n++;
        end
        check("reset_no_relaunch", 32'(n), 32'd0);
        check("reset_ack_low", 32'(Ack), 32'd0);
        push_expected();
        run_full();
        check("post_reset_full_image", 32'(count_out_mismatch()), 32'd0);

        for (int r = 0; r < 4; r++) begin
            fill_dm(8'($urandom_range(0, 40)), tap_list[$urandom_range(0, 8)],
                    8'($urandom), 1'b1);
            push_expected();
            run_full();
            check("random_full_image", 32'(count_out_mismatch()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
